// File: rtl/adder_accum.sv
// Streaming burst accumulator: sums 8-bit operands modulo 2^DATA_WIDTH, tracks a sticky
// wrap flag and a saturating beat count, then presents the total on an output handshake.
module adder_accum #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_carry,
    output logic [CNT_WIDTH-1:0]  out_count
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]   w_acc_nxt;
    logic                    r_carry;
    logic                    w_carry_nxt;
    logic [CNT_WIDTH-1:0]    r_count;
    logic [CNT_WIDTH-1:0]    w_count_nxt;
    logic                    r_live;

    logic                    w_accept;
    logic [DATA_WIDTH:0]     w_sum_wide;
    logic [CNT_WIDTH-1:0]    w_count_inc;
    logic [CNT_WIDTH-1:0]    w_count_one;

    // Holds in_ready low until the first clock edge after reset is released.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign in_ready  = r_live & (r_state != StDone);
    assign w_accept  = in_valid & in_ready;

    assign w_sum_wide  = {1'b0, r_acc} + {1'b0, in_data};
    assign w_count_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    assign w_count_inc = (r_count == {CNT_WIDTH{1'b1}}) ? r_count : r_count + w_count_one;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_carry_nxt = r_carry;
        w_count_nxt = r_count;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_acc_nxt   = in_data;
                    w_carry_nxt = 1'b0;
                    w_count_nxt = w_count_one;
                    w_state_nxt = in_last ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (w_accept) begin
                    w_acc_nxt   = w_sum_wide[DATA_WIDTH-1:0];
                    w_carry_nxt = r_carry | w_sum_wide[DATA_WIDTH];
                    w_count_nxt = w_count_inc;
                    if (in_last) begin
                        w_state_nxt = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_acc_nxt   = '0;
                    w_carry_nxt = 1'b0;
                    w_count_nxt = '0;
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_acc_nxt   = '0;
                w_carry_nxt = 1'b0;
                w_count_nxt = '0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_carry <= w_carry_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Result fields read as zero outside DONE so partial sums never leak downstream.
    assign out_valid = (r_state == StDone);
    assign out_sum   = out_valid ? r_acc   : '0;
    assign out_carry = out_valid ? r_carry : 1'b0;
    assign out_count = out_valid ? r_count : '0;

endmodule

// File: tb/tb_adder_accum.sv
// Directed self-checking bench for adder_accum; inputs change and outputs are sampled on the
// falling clock edge.
module tb_adder_accum;

    logic       clk;
    logic       resetn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_carry;
    logic [3:0] out_count;

    int n_checks;
    int n_errors;

    adder_accum #(
        .DATA_WIDTH(8),
        .CNT_WIDTH (4)
    ) u_dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_carry(out_carry),
        .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] sum, input logic carry,
                                input logic [3:0] count);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"},   {24'd0, out_sum},   {24'd0, sum});
        check({tag, "_carry"}, {31'd0, out_carry}, {31'd0, carry});
        check({tag, "_count"}, {28'd0, out_count}, {28'd0, count});
    endtask

    // Called on a falling edge; returns on the falling edge after the beat is accepted.
    task automatic put(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("put_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum",   {24'd0, out_sum},   32'd0);
        check("rst_out_count", {28'd0, out_count}, 32'd0);
        resetn = 1'b1;
        #1 check("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

        // Single-beat burst, result held until out_ready
        put(8'h5A, 1'b1);
        check_result("single", 8'h5A, 1'b0, 4'd1);
        check("single_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check_result("single_hold", 8'h5A, 1'b0, 4'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("single_idle_valid", {31'd0, out_valid}, 32'd0);
        check("single_idle_ready", {31'd0, in_ready},  32'd1);

        // Back-to-back three-beat burst, result for exactly one cycle
        put(8'h10, 1'b0);
        put(8'h20, 1'b0);
        put(8'h30, 1'b1);
        check_result("three", 8'h60, 1'b0, 4'd3);
        @(negedge clk);
        check("three_one_cycle", {31'd0, out_valid}, 32'd0);
        check("three_idle_ready", {31'd0, in_ready}, 32'd1);

        // Wrapping burst, then carry flag cleared on the next burst
        put(8'hF0, 1'b0);
        put(8'h20, 1'b1);
        check_result("wrap", 8'h10, 1'b1, 4'd2);
        @(negedge clk);
        put(8'h01, 1'b1);
        check_result("after_wrap", 8'h01, 1'b0, 4'd1);
        @(negedge clk);

        // Backpressure: result stable and extra beat refused while out_ready low
        out_ready = 1'b0;
        put(8'h11, 1'b0);
        put(8'h22, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h99;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_result("bp", 8'h33, 1'b0, 4'd2);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready},  32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("bp_next", 8'h99, 1'b0, 4'd1);
        @(negedge clk);

        // Count saturation over 20 beats
        for (int i = 0; i < 20; i++) put(8'h01, (i == 19));
        check_result("sat", 8'h14, 1'b0, 4'd15);
        @(negedge clk);

        // Reset mid-burst discards the partial sum
        put(8'h40, 1'b0);
        put(8'h40, 1'b0);
        resetn = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        end
        resetn = 1'b1;
        #1 check("mid_rel_ready", {31'd0, in_ready}, 32'd0);
        put(8'h07, 1'b1);
        check_result("post_rst", 8'h07, 1'b0, 4'd1);
        @(negedge clk);
        check("post_rst_idle", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
